mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle MIPS multiply/divide unit owning the HI/LO register pair. It sits directly downstream of the register file. It takes the rs/rt operands (register-file read ports one and two) when the decoder issues MULT, MULTU, DIV or DIVU, and iterates for a fixed number of cycles. It then writes the 64-bit product, or the quotient/remainder, into HI/LO for MFHI/MFLO. MTHI/MTLO write HI/LO directly.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request an operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op_a  in  WIDTH  rs operand (multiplicand / dividend)
- op_b  in  WIDTH  rt operand (multiplier / divisor)
- hi_we  in  1  MTHI strobe
- lo_we  in  1  MTLO strobe
- hi_lo_din  in  WIDTH  data for MTHI/MTLO
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO hold a new result
- hi  out  WIDTH  HI register (registered)
- lo  out  WIDTH  LO register (registered)
- div_by_zero  out  1  last DIV/DIVU had op_b == 0; sticky until next accepted start

## Operation
- States: IDLE, RUN, FIX.
- IDLE and start=1:
  - Latch |op_a| and |op_b|. Magnitudes apply only to signed ops (MULT, DIV); unsigned ops take raw values.
  - Latch the sign flags and op.
  - Clear div_by_zero; set busy; iteration counter = 0; go to RUN.
- RUN: one iteration per cycle, WIDTH iterations; counter 0..WIDTH-1; on WIDTH-1 go to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits.
- FIX (single cycle): apply sign correction, write HI/LO, pulse done, clear busy, go to IDLE.
- Sign rules:
  - MULT: 64-bit two's-complement negate of {HI,LO} if sign_a ^ sign_b.
  - DIV: quotient negated if sign_a ^ sign_b; remainder negated if sign_a.
  - Unsigned ops: no correction.
- Placement: product high word to HI, low word to LO. Quotient to LO, remainder to HI.
- Divide by zero (op_b == 0, DIV or DIVU):
  - Full latency is still taken.
  - Result is LO = all ones and HI = op_a as presented at start, not negated.
  - div_by_zero = 1 when done pulses.
- Signed overflow (0x80000000 / 0xFFFFFFFF): natural result LO = 0x80000000, HI = 0; no flag.
- Writes to HI/LO:
  - hi_we / lo_we in IDLE write hi_lo_din on that edge.
  - If start is also asserted on that edge, both the write and the start take effect; the later result overwrites.
  - hi_we / lo_we while busy are ignored.
- start while busy is ignored; op and operand changes during RUN have no effect.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, div_by_zero=0, state IDLE, counter 0.
- rst mid-operation aborts immediately. Outputs take their reset values on the same edge; no done pulse for the aborted operation.
- Latency, with edge E0 the edge that accepts start:
  - busy=1 from after E0 through after E32.
  - FIX occupies the cycle after E32; its edge E33 updates hi/lo/div_by_zero.
  - done=1 for exactly the cycle after E33; busy=0 in that same cycle.
- Throughput: a new start is accepted in the done cycle (state is IDLE); back-to-back operations are therefore 34 edges apart.
- hi/lo change only at FIX, on MTHI/MTLO edges, or on reset; they are stable and readable at all other times, including while busy.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly one cycle, 34 edges after start; busy high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, div_by_zero=1; a following MULTU 2×3 clears div_by_zero at start, then HI=0, LO=6.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> hi=0x1234, lo=0x5678 next cycle. hi_we with 0xDEAD while busy -> ignored. start pulsed while busy -> ignored; exactly one done pulse.
- rst at RUN cycle 10 of DIVU -> busy=0, hi=lo=0, no done pulse. A new start right after rst completes normally with 34-edge latency.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the decoder/register file and the HI/LO multiply-divide unit.
// Inputs are sampled only while the unit is idle; results are held registered on o_hi/o_lo.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_op_a;
  logic [WIDTH-1:0] i_op_b;
  logic             i_hi_we;
  logic             i_lo_we;
  logic [WIDTH-1:0] i_hi_lo_din;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_div_by_zero;

  modport master (
    output i_start, i_op, i_op_a, i_op_b, i_hi_we, i_lo_we, i_hi_lo_din,
    input  o_busy, o_done, o_hi, o_lo, o_div_by_zero
  );

  modport slave (
    input  i_start, i_op, i_op_a, i_op_b, i_hi_we, i_lo_we, i_hi_lo_din,
    output o_busy, o_done, o_hi, o_lo, o_div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO; result lands 33 edges after the accepting edge.
// Starts and MTHI/MTLO writes are ignored while busy, so no backpressure beyond o_busy.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_div_by_zero;

  logic               w_signed_in;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_trial;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed_in = ~bus.i_op[0];
  assign w_a_mag     = (w_signed_in && bus.i_op_a[WIDTH-1]) ? -bus.i_op_a : bus.i_op_a;
  assign w_b_mag     = (w_signed_in && bus.i_op_b[WIDTH-1]) ? -bus.i_op_b : bus.i_op_b;

  // Multiply: upper half accumulates, lower half holds the remaining multiplier bits.
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);

  // Divide: lower half of r_acc shifts dividend bits out and quotient bits in.
  assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_trial = w_div_shift[WIDTH-1:0] - r_b;

  // Sign flags are only ever set for signed ops, so unsigned results pass through.
  assign w_prod      = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  // A zero divisor leaves rem = |a|, so the remainder rule hands back op_a unchanged.
  assign w_quot      = ((r_sign_a ^ r_sign_b) && !r_dbz) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix   = r_sign_a ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_is_div      <= 1'b0;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_dbz         <= 1'b0;
      r_b           <= '0;
      r_acc         <= '0;
      r_rem         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_hi_we) r_hi <= bus.i_hi_lo_din;
          if (bus.i_lo_we) r_lo <= bus.i_hi_lo_din;
          if (bus.i_start) begin
            r_is_div      <= bus.i_op[1];
            r_sign_a      <= w_signed_in & bus.i_op_a[WIDTH-1];
            r_sign_b      <= w_signed_in & bus.i_op_b[WIDTH-1];
            r_dbz         <= bus.i_op[1] && (bus.i_op_b == '0);
            r_b           <= bus.i_op[1] ? w_b_mag : w_a_mag;
            r_acc         <= {{WIDTH{1'b0}}, (bus.i_op[1] ? w_a_mag : w_b_mag)};
            r_rem         <= '0;
            r_cnt         <= '0;
            r_div_by_zero <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= RUN;
          end
        end
        RUN: begin
          if (r_is_div) begin
            r_rem             <= w_div_ge ? w_div_trial : w_div_shift[WIDTH-1:0];
            r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], w_div_ge};
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_div_by_zero <= r_dbz;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_hi          = r_hi;
  assign bus.o_lo          = r_lo;
  assign bus.o_div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases, MTHI/MTLO, busy interference, reset abort, random ops vs arithmetic model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS truncating division, fixed divide-by-zero result.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    dbz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      2'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dbz = 1'b1; hi = a; lo = 32'hFFFFFFFF;
        end else if (op == 2'd2) begin
          sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0];
        end else begin
          up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0];
        end
      end
    endcase
  endfunction

  // Entered and left at a negedge; on return the done cycle is current, so a following call starts back-to-back.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edbz,
                        input bit disturb, input bit wr_at_start);
    int lat;
    int busy_cnt;
    bit seen;
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_op_a  = a;
    bus.i_op_b  = b;
    if (wr_at_start) begin
      bus.i_lo_we     = 1'b1;
      bus.i_hi_lo_din = 32'hCAFE0000;
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_lo_we = 1'b0;
    bus.i_op_a  = $urandom;
    bus.i_op_b  = $urandom;
    if (wr_at_start) begin
      m_lo = 32'hCAFE0000;
      check({tag, ":mtlo_with_start"}, bus.o_lo, m_lo);
    end
    check({tag, ":busy_after_start"}, bus.o_busy, 1);
    check({tag, ":done_low_after_start"}, bus.o_done, 0);
    check({tag, ":dbz_cleared"}, bus.o_div_by_zero, 0);
    lat = 1;
    busy_cnt = 1;
    seen = 0;
    while (!seen && lat < 100) begin
      if (disturb && lat == 10) begin
        bus.i_start     = 1'b1;
        bus.i_op        = ~op;
        bus.i_hi_we     = 1'b1;
        bus.i_lo_we     = 1'b1;
        bus.i_hi_lo_din = 32'hDEAD;
      end else begin
        bus.i_start = 1'b0;
        bus.i_hi_we = 1'b0;
        bus.i_lo_we = 1'b0;
      end
      if (lat == 20) check({tag, ":hilo_stable_busy"}, {bus.o_hi, bus.o_lo}, {m_hi, m_lo});
      @(negedge clk);
      lat++;
      if (bus.o_done) seen = 1;
      else if (bus.o_busy) busy_cnt++;
    end
    check({tag, ":latency"}, lat, 34);
    check({tag, ":busy_cycles"}, busy_cnt, 33);
    check({tag, ":busy_low_in_done"}, bus.o_busy, 0);
    check({tag, ":hi"}, bus.o_hi, eh);
    check({tag, ":lo"}, bus.o_lo, el);
    check({tag, ":dbz"}, bus.o_div_by_zero, edbz);
    m_hi = eh;
    m_lo = el;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    bit          disturb, wr;
  } vec_t;

  vec_t dir[8];

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    logic        edbz;
    int          pick;

    dir[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 1'b0};
    dir[1] = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1, 1'b0};
    dir[2] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    dir[3] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1};
    dir[4] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0, 1'b0};
    dir[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    dir[6] = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    dir[7] = '{2'd1, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.i_start = 0; bus.i_op = 0; bus.i_op_a = 0; bus.i_op_b = 0;
    bus.i_hi_we = 0; bus.i_lo_we = 0; bus.i_hi_lo_din = 0;
    repeat (3) @(negedge clk);
    check("reset:busy", bus.o_busy, 0);
    check("reset:done", bus.o_done, 0);
    check("reset:hi", bus.o_hi, 0);
    check("reset:lo", bus.o_lo, 0);
    check("reset:dbz", bus.o_div_by_zero, 0);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);

    foreach (dir[i])
      run_op($sformatf("dir%0d", i), dir[i].op, dir[i].a, dir[i].b,
             dir[i].hi, dir[i].lo, dir[i].dbz, dir[i].disturb, dir[i].wr);

    @(negedge clk);
    check("done_one_cycle", bus.o_done, 0);
    bus.i_hi_we = 1'b1; bus.i_hi_lo_din = 32'h1234;
    @(negedge clk);
    bus.i_hi_we = 1'b0; bus.i_lo_we = 1'b1; bus.i_hi_lo_din = 32'h5678;
    @(negedge clk);
    bus.i_lo_we = 1'b0;
    check("mthi", bus.o_hi, 32'h1234);
    check("mtlo", bus.o_lo, 32'h5678);
    m_hi = 32'h1234;
    m_lo = 32'h5678;

    // Abort a DIVU at RUN cycle 10, then start again immediately.
    bus.i_start = 1'b1; bus.i_op = 2'd3; bus.i_op_a = 32'd1000; bus.i_op_b = 32'd3;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort:busy", bus.o_busy, 0);
    check("abort:done", bus.o_done, 0);
    check("abort:hi", bus.o_hi, 0);
    check("abort:lo", bus.o_lo, 0);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    run_op("after_abort", 2'd3, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) b = 32'd0;
      if (pick == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (pick == 2) b = $urandom_range(1, 15);
      if (pick == 3) a = $urandom_range(0, 255);
      ref_model(op, a, b, eh, el, edbz);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, eh, el, edbz, (pick == 4), (pick == 5));
    end

    @(negedge clk);
    check("final_done_low", bus.o_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
